axil_cmd_master: RTL and testbench

Parametrised, synthesizable AXI4-Lite master that turns a valid/ready command stream into single AXI4-Lite write or read transactions and returns one response per command. Each command carries its own byte strobe; reads can be checked against an expected value with a mask, and the block counts and flags any mismatch. Per-transaction timeouts and error counters are also provided. It sits between a command source (MicroBlaze-side sequencer, boot-time palette/VRAM loader, or bench stimulus) and any AXI4-Lite slave such as the HDMI text controller register/VRAM port.

---
 rtl/axil_pkg.sv | 35 +++
 rtl/axil_cmd_master_if.sv | 44 ++++
 rtl/axil_cmd_master_sat_counter.sv | 20 ++
 rtl/axil_cmd_master.sv | 262 ++++++++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared types and response codes for the AXI4-Lite command master
package axil_pkg;

    localparam int AXIL_ADDR_W = 16;
    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } axil_state_e;

    typedef struct packed {
        logic                   write;
        logic [AXIL_ADDR_W-1:0] addr;
        logic [AXIL_DATA_W-1:0] data;
        logic [AXIL_STRB_W-1:0] strb;
        logic                   check;
        logic [AXIL_DATA_W-1:0] mask;
    } axil_cmd_t;

    function automatic logic rsp_is_err(input logic [1:0] resp, input logic mismatch,
                                        input logic timeout);
        return (resp != RESP_OKAY) || mismatch || timeout;
    endfunction

endpackage

// File: rtl/axil_cmd_master_if.sv
// rtl/axil_cmd_master_if.sv - AXI4-Lite bus bundle with master/slave views
interface axil_cmd_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axil_cmd_master_sat_counter.sv
// rtl/axil_cmd_master_sat_counter.sv - up counter that sticks at all-ones
module axil_cmd_master_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - command stream to single AXI4-Lite transactions with check and timeout
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int  ADDR_W  = 16,
    parameter int  DATA_W  = 32,
    parameter int  TIMEOUT = 1024,
    parameter int  CNT_W   = 16,
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic              axi_aclk,
    input  logic              axi_reset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [STRB_W-1:0] cmd_strb,
    input  logic              cmd_check,
    input  logic [DATA_W-1:0] cmd_mask,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_resp,
    output logic              rsp_mismatch,
    output logic              rsp_timeout,

    axil_cmd_master_if.master m_axi,

    output logic [CNT_W-1:0]  txn_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              busy
);

    localparam int TO_W = $clog2(TIMEOUT);

    axil_state_e       state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [STRB_W-1:0] strb_q, strb_d;
    logic              check_q, check_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              rsp_mismatch_q, rsp_mismatch_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              to_expired;
    logic              timeout_hit;
    logic              rsp_fire;
    logic              err_inc;

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q        <= IDLE;
            cmd_ready_q    <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            strb_q         <= '0;
            check_q        <= 1'b0;
            mask_q         <= '0;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            bready_q       <= 1'b0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_resp_q     <= RESP_OKAY;
            rsp_mismatch_q <= 1'b0;
            rsp_timeout_q  <= 1'b0;
            to_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            cmd_ready_q    <= cmd_ready_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            strb_q         <= strb_d;
            check_q        <= check_d;
            mask_q         <= mask_d;
            awvalid_q      <= awvalid_d;
            wvalid_q       <= wvalid_d;
            bready_q       <= bready_d;
            arvalid_q      <= arvalid_d;
            rready_q       <= rready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_resp_q     <= rsp_resp_d;
            rsp_mismatch_q <= rsp_mismatch_d;
            rsp_timeout_q  <= rsp_timeout_d;
            to_cnt_q       <= to_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cmd_ready_d    = cmd_ready_q;
        addr_d         = addr_q;
        data_d         = data_q;
        strb_d         = strb_q;
        check_d        = check_q;
        mask_d         = mask_q;
        awvalid_d      = awvalid_q;
        wvalid_d       = wvalid_q;
        bready_d       = bready_q;
        arvalid_d      = arvalid_q;
        rready_d       = rready_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_data_d     = rsp_data_q;
        rsp_resp_d     = rsp_resp_q;
        rsp_mismatch_d = rsp_mismatch_q;
        rsp_timeout_d  = rsp_timeout_q;
        timeout_hit    = 1'b0;
        to_expired     = (to_cnt_q == TO_W'(TIMEOUT - 1));

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr;
                    data_d      = cmd_data;
                    strb_d      = cmd_strb;
                    check_d     = cmd_check;
                    mask_d      = cmd_mask;
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                // AW and W retire independently; a completed handshake beats an expiring timer
                awvalid_d = awvalid_q && !m_axi.awready;
                wvalid_d  = wvalid_q && !m_axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end else begin
                    timeout_hit = to_expired;
                end
            end
            WR_RESP: begin
                if (m_axi.bvalid) begin
                    bready_d       = 1'b0;
                    state_d        = RSP;
                    rsp_valid_d    = 1'b1;
                    rsp_data_d     = '0;
                    rsp_resp_d     = m_axi.bresp;
                    rsp_mismatch_d = 1'b0;
                    rsp_timeout_d  = 1'b0;
                end else begin
                    timeout_hit = to_expired;
                end
            end
            RD_REQ: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end else begin
                    timeout_hit = to_expired;
                end
            end
            RD_DATA: begin
                if (m_axi.rvalid) begin
                    rready_d       = 1'b0;
                    state_d        = RSP;
                    rsp_valid_d    = 1'b1;
                    rsp_data_d     = m_axi.rdata;
                    rsp_resp_d     = m_axi.rresp;
                    rsp_mismatch_d = check_q && (|((m_axi.rdata ^ data_q) & mask_q));
                    rsp_timeout_d  = 1'b0;
                end else begin
                    timeout_hit = to_expired;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout_hit) begin
            awvalid_d      = 1'b0;
            wvalid_d       = 1'b0;
            bready_d       = 1'b0;
            arvalid_d      = 1'b0;
            rready_d       = 1'b0;
            state_d        = RSP;
            rsp_valid_d    = 1'b1;
            rsp_data_d     = '0;
            rsp_resp_d     = RESP_SLVERR;
            rsp_mismatch_d = 1'b0;
            rsp_timeout_d  = 1'b1;
        end

        // Timer restarts on every state change and only runs inside the four bus-wait states
        if ((state_d != state_q) || (state_q == IDLE) || (state_q == RSP)) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    assign rsp_fire = (state_q == RSP) && rsp_ready;
    assign err_inc  = rsp_fire && rsp_is_err(rsp_resp_q, rsp_mismatch_q, rsp_timeout_q);

    axil_cmd_master_sat_counter #(.W(CNT_W)) u_txn_cnt (
        .clk   (axi_aclk),
        .rst   (axi_reset),
        .clear (1'b0),
        .inc   (rsp_fire),
        .count (txn_cnt)
    );

    axil_cmd_master_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (axi_aclk),
        .rst   (axi_reset),
        .clear (1'b0),
        .inc   (err_inc),
        .count (err_cnt)
    );

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_resp     = rsp_resp_q;
    assign rsp_mismatch = rsp_mismatch_q;
    assign rsp_timeout  = rsp_timeout_q;
    assign busy         = (state_q != IDLE);

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = data_q;
    assign m_axi.wstrb   = strb_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// tb/tb_axil_cmd_master.sv - directed bench for axil_cmd_master with a latency-programmable slave
module tb_axil_cmd_master;
    import axil_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          axi_reset;
    logic          cmd_valid, cmd_ready, cmd_write, cmd_check;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data, cmd_mask;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid, rsp_ready, rsp_mismatch, rsp_timeout;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_resp;
    logic [CW-1:0] txn_cnt, err_cnt;
    logic          busy;

    axil_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    axil_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16), .CNT_W(CW)) dut (
        .axi_aclk(clk), .axi_reset(axi_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
        .cmd_check(cmd_check), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_mismatch(rsp_mismatch), .rsp_timeout(rsp_timeout),
        .m_axi(bus),
        .txn_cnt(txn_cnt), .err_cnt(err_cnt), .busy(busy)
    );

    // Slave: each ready rises after its valid has waited *_lat cycles
    int          aw_lat = 0, w_lat = 0, ar_lat = 0;
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;
    logic        late_r = 1'b0;
    logic        s_bvalid, s_rvalid, s_aw_got, s_w_got;
    logic [31:0] s_rdata, s_wdata;
    logic [15:0] s_awaddr;
    logic [3:0]  s_wstrb;
    logic [31:0] mem [0:15];
    logic        aw_hs, w_hs, ar_hs, have_aw, have_w;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    assign bus.awready = bus.awvalid && (aw_wait >= aw_lat);
    assign bus.wready  = bus.wvalid && (w_wait >= w_lat);
    assign bus.arready = bus.arvalid && (ar_wait >= ar_lat);
    assign bus.bvalid  = s_bvalid;
    assign bus.bresp   = 2'b00;
    assign bus.rvalid  = s_rvalid | late_r;
    assign bus.rdata   = s_rdata;
    assign bus.rresp   = 2'b00;

    assign aw_hs   = bus.awvalid && bus.awready;
    assign w_hs    = bus.wvalid && bus.wready;
    assign ar_hs   = bus.arvalid && bus.arready;
    assign have_aw = s_aw_got || aw_hs;
    assign have_w  = s_w_got || w_hs;
    assign wr_addr = aw_hs ? bus.awaddr : s_awaddr;
    assign wr_data = w_hs ? bus.wdata : s_wdata;
    assign wr_strb = w_hs ? bus.wstrb : s_wstrb;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (axi_reset) begin
            s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_aw_got <= 1'b0; s_w_got <= 1'b0;
            s_rdata  <= '0;   s_wdata  <= '0;   s_awaddr <= '0;   s_wstrb <= '0;
            aw_wait  <= 0;    w_wait   <= 0;    ar_wait  <= 0;
            mem[0] <= 32'h0; mem[1] <= 32'h69207420; mem[2] <= 32'h0; mem[3] <= 32'h0;
        end else begin
            aw_wait <= (bus.awvalid && !bus.awready) ? aw_wait + 1 : 0;
            w_wait  <= (bus.wvalid && !bus.wready) ? w_wait + 1 : 0;
            ar_wait <= (bus.arvalid && !bus.arready) ? ar_wait + 1 : 0;
            if (have_aw && have_w && !s_bvalid) begin
                mem[wr_addr[5:2]] <= merge(mem[wr_addr[5:2]], wr_data, wr_strb);
                s_bvalid <= 1'b1;
                s_aw_got <= 1'b0;
                s_w_got  <= 1'b0;
            end else begin
                if (aw_hs) begin s_aw_got <= 1'b1; s_awaddr <= bus.awaddr; end
                if (w_hs) begin s_w_got <= 1'b1; s_wdata <= bus.wdata; s_wstrb <= bus.wstrb; end
            end
            if (s_bvalid && bus.bready) s_bvalid <= 1'b0;
            if (ar_hs) begin
                s_rvalid <= 1'b1;
                s_rdata  <= mem[bus.araddr[5:2]];
            end else if (s_rvalid && bus.rready) begin
                s_rvalid <= 1'b0;
            end
        end
    end

    // Monitor: samples at negedge, records the edge number at which each event takes effect
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   cmd_edge = 0, cmd_hs = 0, gap4 = 0;
    int   aw_edge = 0, w_edge = 0, b_edge = 0, ar_edge = 0, r_edge = 0;
    int   aw_beats = 0, w_beats = 0, ar_high = 0, rr_high = 0;
    int   bready_edge = 0, rsp_edge = 0;
    logic bready_prev = 1'b0, rsp_prev = 1'b0;
    logic [3:0] last_wstrb = '0;

    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) begin
            cmd_edge <= cyc + 1;
            cmd_hs   <= cmd_hs + 1;
            if (cyc + 1 - cmd_edge == 4) gap4 <= gap4 + 1;
        end
        if (aw_hs) begin aw_edge <= cyc + 1; aw_beats <= aw_beats + 1; end
        if (w_hs) begin w_edge <= cyc + 1; w_beats <= w_beats + 1; last_wstrb <= bus.wstrb; end
        if (bus.bvalid && bus.bready) b_edge <= cyc + 1;
        if (ar_hs) ar_edge <= cyc + 1;
        if (bus.rvalid && bus.rready) r_edge <= cyc + 1;
        if (bus.arvalid) ar_high <= ar_high + 1;
        if (bus.rready) rr_high <= rr_high + 1;
        if (bus.bready && !bready_prev) bready_edge <= cyc + 1;
        if (rsp_valid && !rsp_prev) rsp_edge <= cyc + 1;
        bready_prev <= bus.bready;
        rsp_prev    <= rsp_valid;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_mm, r_to;

    task automatic send(input logic wr, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic ck, input logic [31:0] m);
        int n;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d;
        cmd_strb = s; cmd_check = ck; cmd_mask = m;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        chk("cmd_accept", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 100) begin tick(); n++; end
        chk("rsp_arrive", rsp_valid, 1);
        r_data = rsp_data; r_resp = rsp_resp; r_mm = rsp_mismatch; r_to = rsp_timeout;
        tick();
    endtask

    int n0, aw0, w0, ar0, rr0, tx0, hs0, g0, k;

    initial begin
        axi_reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
        cmd_strb = '0; cmd_check = 1'b0; cmd_mask = '0; rsp_ready = 1'b1;
        repeat (3) tick();
        chk("rst_awvalid", bus.awvalid, 0);
        chk("rst_wvalid", bus.wvalid, 0);
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_bready", bus.bready, 0);
        chk("rst_rready", bus.rready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_awaddr", bus.awaddr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_txn", txn_cnt, 0);
        axi_reset = 1'b0;
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);

        // Zero-wait write latency
        aw0 = aw_beats; w0 = w_beats;
        send(1'b1, 16'h2002, 32'h0FFF0000, 4'hF, 1'b0, 32'h0);
        n0 = cmd_edge;
        chk("wr_busy", busy, 1);
        chk("wr_cmd_ready_low", cmd_ready, 0);
        wait_rsp();
        chk("wr_aw_edge", aw_edge, n0 + 1);
        chk("wr_w_edge", w_edge, n0 + 1);
        chk("wr_bready_edge", bready_edge, n0 + 2);
        chk("wr_b_edge", b_edge, n0 + 2);
        chk("wr_rsp_edge", rsp_edge, n0 + 3);
        chk("wr_resp", r_resp, 2'b00);
        chk("wr_rsp_data", r_data, 0);
        chk("wr_beats", (aw_beats - aw0) * 16 + (w_beats - w0), 17);
        chk("wr_txn", txn_cnt, 1);

        // W before AW by 3 cycles, then the reverse order
        for (int order = 0; order < 2; order++) begin
            aw_lat = (order == 0) ? 3 : 0;
            w_lat  = (order == 0) ? 0 : 3;
            aw0 = aw_beats; w0 = w_beats;
            send(1'b1, (order == 0) ? 16'h0008 : 16'h000C,
                 (order == 0) ? 32'h11111111 : 32'h22222222, 4'hF, 1'b0, 32'h0);
            n0 = cmd_edge;
            tick();
            chk("ord_awvalid", bus.awvalid, (order == 0) ? 1 : 0);
            chk("ord_wvalid", bus.wvalid, (order == 0) ? 0 : 1);
            wait_rsp();
            chk("ord_aw_edge", aw_edge, n0 + ((order == 0) ? 4 : 1));
            chk("ord_w_edge", w_edge, n0 + ((order == 0) ? 1 : 4));
            chk("ord_b_edge", b_edge, n0 + 5);
            chk("ord_beats", (aw_beats - aw0) * 16 + (w_beats - w0), 17);
            chk("ord_resp", r_resp, 2'b00);
        end
        aw_lat = 0; w_lat = 0;

        // Checked reads
        send(1'b0, 16'h0004, 32'h69207420, 4'h0, 1'b1, 32'hFFFFFFFF);
        n0 = cmd_edge;
        wait_rsp();
        chk("rd_ar_edge", ar_edge, n0 + 1);
        chk("rd_r_edge", r_edge, n0 + 2);
        chk("rd_rsp_edge", rsp_edge, n0 + 3);
        chk("rd_data", r_data, 32'h69207420);
        chk("rd_mm_eq", r_mm, 0);
        send(1'b0, 16'h0004, 32'h69207421, 4'h0, 1'b1, 32'hFFFFFFFF);
        wait_rsp();
        chk("rd_mm_diff", r_mm, 1);
        chk("rd_err_cnt", err_cnt, 1);
        send(1'b0, 16'h0004, 32'h69207421, 4'h0, 1'b1, 32'hFFFFFFFE);
        wait_rsp();
        chk("rd_mm_masked", r_mm, 0);
        chk("rd_err_hold", err_cnt, 1);

        // Partial strobe write then readback
        send(1'b1, 16'h0002, 32'h0000ABCD, 4'h3, 1'b0, 32'h0);
        wait_rsp();
        chk("strb_bus", last_wstrb, 4'h3);
        send(1'b0, 16'h0002, 32'h0, 4'h0, 1'b0, 32'h0);
        wait_rsp();
        chk("strb_readback", r_data, 32'h0FFFABCD);

        // AR never accepted
        ar_lat = 100000;
        ar0 = ar_high; rr0 = rr_high;
        send(1'b0, 16'h0010, 32'h0, 4'h0, 1'b0, 32'h0);
        n0 = cmd_edge;
        wait_rsp();
        chk("to_ar_cycles", ar_high - ar0, 16);
        chk("to_rsp_edge", rsp_edge, n0 + 17);
        chk("to_flag", r_to, 1);
        chk("to_resp", r_resp, 2'b10);
        chk("to_err_cnt", err_cnt, 2);
        chk("to_arvalid", bus.arvalid, 0);
        ar_lat = 0;
        tx0 = txn_cnt;
        late_r = 1'b1;
        repeat (5) tick();
        late_r = 1'b0;
        tick();
        chk("late_rready", rr_high - rr0, 0);
        chk("late_rsp_valid", rsp_valid, 0);
        chk("late_txn", txn_cnt, tx0);
        chk("pre_stream_txn", txn_cnt, 9);

        // Fresh start, then 1200 back-to-back checked reads
        axi_reset = 1'b1;
        repeat (2) tick();
        axi_reset = 1'b0;
        tick();
        chk("rst2_txn", txn_cnt, 0);
        chk("rst2_err", err_cnt, 0);
        hs0 = cmd_hs; g0 = gap4;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0004; cmd_data = 32'h69207420;
        cmd_check = 1'b1; cmd_mask = 32'hFFFFFFFF; cmd_strb = 4'h0;
        k = 0;
        while ((cmd_hs - hs0) < 1200 && k < 6000) begin tick(); k++; end
        cmd_valid = 1'b0;
        k = 0;
        while (busy && k < 50) begin tick(); k++; end
        tick();
        chk("stream_busy", busy, 0);
        chk("stream_txn", txn_cnt, 1200);
        chk("stream_err", err_cnt, 0);
        chk("stream_gap4", gap4 - g0, 1199);

        // Reset in the middle of a stalled write
        aw_lat = 5; w_lat = 5;
        send(1'b1, 16'h0008, 32'h33333333, 4'hF, 1'b0, 32'h0);
        tick();
        chk("mid_awvalid_pre", bus.awvalid, 1);
        axi_reset = 1'b1;
        tick();
        chk("mid_awvalid", bus.awvalid, 0);
        chk("mid_wvalid", bus.wvalid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_txn", txn_cnt, 0);
        chk("mid_err", err_cnt, 0);
        axi_reset = 1'b0;
        aw_lat = 0; w_lat = 0;
        tick();
        chk("mid_cmd_ready", cmd_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
